// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a single-address-byte AT24-style EEPROM.
// SCL/SDA are oversampled on clk; SDA is driven open-drain (0 or Z only).
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         ADDR_W   = 8,
    parameter int         FILT     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i2c_scl,
    inout  wire               i2c_sda,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
    // state    | meaning
    // IDLE     | bus ignored until START
    // DEVADDR  | shifting in device address + R/W
    // ACK_DEV  | driving ACK for device address
    // WORDADDR | shifting in word address
    // ACK_WA   | driving ACK for word address
    // RXDATA   | shifting in a write data byte
    // ACK_RX   | driving ACK for a data byte
    // TXDATA   | shifting out a read data byte
    // MACK     | sampling master ACK/NACK
    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, WORDADDR, ACK_WA, RXDATA, ACK_RX, TXDATA, MACK
    } state_t;

    localparam int           FW       = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [FW-1:0] FLT_LOAD = FW'(FILT - 1);

    logic [1:0]    sync0, sync1, filt, filt_q;
    logic [FW-1:0] flt_cnt [2];

    // bit 1 = SCL, bit 0 = SDA; a new level is accepted after FILT differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0      <= 2'b11;
            sync1      <= 2'b11;
            filt       <= 2'b11;
            filt_q     <= 2'b11;
            flt_cnt[0] <= FLT_LOAD;
            flt_cnt[1] <= FLT_LOAD;
        end else begin
            sync0  <= {i2c_scl, i2c_sda};
            sync1  <= sync0;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] == filt[i]) begin
                    flt_cnt[i] <= FLT_LOAD;
                end else if (flt_cnt[i] == '0) begin
                    filt[i]    <= sync1[i];
                    flt_cnt[i] <= FLT_LOAD;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] - 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  filt[1] & ~filt_q[1];
    assign scl_fall  = ~filt[1] &  filt_q[1];
    assign start_det =  filt[1] &  filt_q[1] & ~filt[0] &  filt_q[0];
    assign stop_det  =  filt[1] &  filt_q[1] &  filt[0] & ~filt_q[0];

    state_t            state, state_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt, ptr_inc;
    logic              rw, rw_nxt, sda_oe, sda_oe_nxt, busy_nxt;
    logic              wr_valid_nxt, mem_we;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [7:0]        wr_data_nxt, rx_byte;
    logic [7:0]        mem [2**ADDR_W];

    assign ptr_inc = ptr + ADDR_W'(1);
    assign rx_byte = {shreg[6:0], filt[0]};
    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        ptr_nxt      = ptr;
        rw_nxt       = rw;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        wr_valid_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        mem_we       = 1'b0;
        case (state)
            IDLE: ;
            DEVADDR, WORDADDR, RXDATA: begin
                if (scl_rise) begin
                    shreg_nxt   = rx_byte;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (state == RXDATA && bit_cnt == 4'd7) begin
                        mem_we       = 1'b1;
                        wr_valid_nxt = 1'b1;
                        wr_addr_nxt  = ptr;
                        wr_data_nxt  = rx_byte;
                        ptr_nxt      = ptr_inc;
                    end
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    sda_oe_nxt = 1'b1;
                    if (state == DEVADDR) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            rw_nxt    = shreg[0];
                            busy_nxt  = 1'b1;
                            state_nxt = ACK_DEV;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                            state_nxt  = IDLE;
                        end
                    end else if (state == WORDADDR) begin
                        ptr_nxt   = shreg[ADDR_W-1:0];
                        state_nxt = ACK_WA;
                    end else begin
                        state_nxt = ACK_RX;
                    end
                end
            end
            ACK_DEV: begin
                if (scl_fall) begin
                    bit_cnt_nxt = 4'd0;
                    sda_oe_nxt  = 1'b0;
                    state_nxt   = WORDADDR;
                    if (rw) begin
                        // first read bit goes out on the same fall that ends the ACK
                        shreg_nxt   = {mem[ptr][6:0], 1'b0};
                        sda_oe_nxt  = ~mem[ptr][7];
                        bit_cnt_nxt = 4'd1;
                        state_nxt   = TXDATA;
                    end
                end
            end
            ACK_WA, ACK_RX: begin
                if (scl_fall) begin
                    sda_oe_nxt  = 1'b0;
                    bit_cnt_nxt = 4'd0;
                    state_nxt   = RXDATA;
                end
            end
            TXDATA: begin
                if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = MACK;
                    end else begin
                        sda_oe_nxt  = ~shreg[7];
                        shreg_nxt   = {shreg[6:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            MACK: begin
                if (scl_rise) begin
                    ptr_nxt = ptr_inc;
                    if (!filt[0]) begin
                        shreg_nxt   = mem[ptr_inc];
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = TXDATA;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (stop_det) begin
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            state_nxt  = IDLE;
        end else if (start_det) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = DEVADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            ptr      <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            ptr      <= ptr_nxt;
            rw       <= rw_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            wr_valid <= wr_valid_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= rx_byte;
    end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master against a byte-array EEPROM model.
module tb_i2c_eeprom_slave;
    localparam int         Q   = 8;
    localparam logic [6:0] DEV = 7'h50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        i2c_sda;
    logic       wr_valid;
    logic [7:0] wr_addr, wr_data;
    logic       busy;

    assign i2c_sda = m_sda ? 1'bz : 1'b0;
    pullup (i2c_sda);

    always #5 clk = ~clk;

    i2c_eeprom_slave #(.DEV_ADDR(DEV), .ADDR_W(8), .FILT(3)) dut (
        .clk(clk), .rst_n(rst_n), .i2c_scl(m_scl), .i2c_sda(i2c_sda),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    int          total = 0, bad = 0;
    logic [7:0]  mm [256];
    bit          kn [256];
    logic [7:0]  mptr = 8'h00;
    logic [7:0]  wq [$];
    logic [15:0] obs_q [$], exp_q [$];
    int          hi_changes = 0, slave_lows = 0;
    bit          mon_en = 1'b1, prev_drv = 1'b0;

    // slave-side activity seen on the wire, sampled away from the active edge
    always @(negedge clk) begin : mon
        bit drv;
        drv = m_sda && (i2c_sda === 1'b0);
        if (wr_valid) obs_q.push_back({wr_addr, wr_data});
        if (mon_en && m_scl && drv != prev_drv) hi_changes++;
        if (drv) slave_lows++;
        prev_drv = drv;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, input bit glitch, output logic r);
        wait_q();
        m_sda = b;
        if (glitch) begin
            repeat (2) @(negedge clk);
            m_scl = 1'b1;
            @(negedge clk);
            m_scl = 1'b0;
            repeat (Q - 3) @(negedge clk);
        end else begin
            wait_q();
        end
        m_scl = 1'b1;
        wait_q();
        r = i2c_sda;
        wait_q();
        m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q(); m_sda = 1'b1;
        wait_q(); m_scl = 1'b1;
        wait_q(); m_sda = 1'b0;
        wait_q(); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); m_sda = 1'b0;
        wait_q(); m_scl = 1'b1;
        wait_q(); m_sda = 1'b1;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_at, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], i == glitch_at, r);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, r);
            d[i] = r;
        end
        bit_xfer(mack, 1'b0, r);
    endtask

    task automatic check_wr();
        check("wr_count", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < obs_q.size()) check("wr_addr_data", obs_q[k], exp_q[k]);
    endtask

    // data bytes come from wq; pbits bits of pbyte follow before STOP
    task automatic do_write(input logic [7:0] addr, input int pbits, input logic [7:0] pbyte,
                            input int glitch_at);
        logic a, r;
        obs_q.delete(); exp_q.delete();
        i2c_start();
        write_byte({DEV, 1'b0}, -1, a);
        check("dev_ack", a, 1'b0);
        check("busy_hi", busy, 1'b1);
        write_byte(addr, -1, a);
        check("wa_ack", a, 1'b0);
        mptr = addr;
        foreach (wq[k]) begin
            write_byte(wq[k], glitch_at, a);
            check("wd_ack", a, 1'b0);
            mm[mptr] = wq[k];
            kn[mptr] = 1'b1;
            exp_q.push_back({mptr, wq[k]});
            mptr++;
        end
        for (int i = 0; i < pbits; i++) bit_xfer(pbyte[7-i], 1'b0, r);
        i2c_stop();
        check("busy_lo", busy, 1'b0);
        check_wr();
    endtask

    task automatic do_read(input bit rnd, input logic [7:0] addr, input int n);
        logic a;
        logic [7:0] d;
        obs_q.delete();
        i2c_start();
        if (rnd) begin
            write_byte({DEV, 1'b0}, -1, a);
            check("rr_dev_ack", a, 1'b0);
            write_byte(addr, -1, a);
            check("rr_wa_ack", a, 1'b0);
            mptr = addr;
            i2c_start();
        end
        write_byte({DEV, 1'b1}, -1, a);
        check("rd_dev_ack", a, 1'b0);
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, d);
            if (kn[mptr]) check("rd_data", d, mm[mptr]);
            mptr++;
        end
        i2c_stop();
        check("rd_busy_lo", busy, 1'b0);
        check("rd_no_wr", obs_q.size(), 0);
    endtask

    task automatic do_mismatch(input logic [6:0] a7);
        logic a;
        obs_q.delete();
        slave_lows = 0;
        i2c_start();
        write_byte({a7, 1'b0}, -1, a);
        check("nm_ack", a, 1'b1);
        write_byte(8'($urandom), -1, a);
        check("nm_ack2", a, 1'b1);
        i2c_stop();
        check("nm_no_drive", slave_lows, 0);
        check("nm_no_wr", obs_q.size(), 0);
        check("nm_busy", busy, 1'b0);
    endtask

    task automatic do_reset_during_ack();
        logic r;
        logic [7:0] d;
        obs_q.delete();
        d = {DEV, 1'b0};
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], 1'b0, r);
        wait_q();
        m_sda = 1'b1;
        wait_q();
        check("ack_driven", i2c_sda, 1'b0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_sda_z", i2c_sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_scl = 1'b1;
        wait_q(); wait_q();
        check("post_rst_sda", i2c_sda, 1'b1);
        m_scl = 1'b0;
        i2c_stop();
        mon_en = 1'b1;
        mptr = 8'h00;
        check("rst_no_wr", obs_q.size(), 0);
    endtask

    initial begin : main
        logic [7:0] last_wa;
        logic [6:0] a7;
        int op;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h00);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_sda", i2c_sda, 1'b1);

        wq.delete(); wq.push_back(8'h77); do_write(8'h06, 0, 8'h00, -1);
        wq.delete(); wq.push_back(8'h3C); do_write(8'h05, 0, 8'h00, -1);
        do_read(1'b1, 8'h05, 1);
        do_read(1'b0, 8'h00, 1);

        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        do_write(8'hFE, 0, 8'h00, -1);
        do_read(1'b1, 8'hFE, 3);

        do_mismatch(7'h51);

        wq.delete(); wq.push_back(8'h5A); do_write(8'h12, 0, 8'h00, -1);
        wq.delete(); wq.push_back(8'hAA); wq.push_back(8'hBB);
        do_write(8'h10, 4, 8'hCC, -1);
        check("abort_sda_z", i2c_sda, 1'b1);
        do_read(1'b1, 8'h10, 3);

        wq.delete(); wq.push_back(8'h96); wq.push_back(8'h69);
        do_write(8'h40, 0, 8'h00, 3);
        do_read(1'b1, 8'h40, 2);

        do_reset_during_ack();
        do_read(1'b0, 8'h00, 1);

        last_wa = 8'h40;
        for (int it = 0; it < 14; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    last_wa = 8'($urandom);
                    wq.delete();
                    repeat ($urandom_range(1, 4)) wq.push_back(8'($urandom));
                    if ($urandom_range(0, 1) == 1)
                        do_write(last_wa, int'($urandom_range(1, 6)), 8'($urandom), -1);
                    else
                        do_write(last_wa, 0, 8'h00, -1);
                end
                1: do_read(1'b1, last_wa, int'($urandom_range(1, 4)));
                2: do_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
                default: begin
                    do a7 = 7'($urandom); while (a7 == DEV);
                    do_mismatch(a7);
                end
            endcase
        end

        check("sda_change_scl_high", hi_changes, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
